// File: rtl/seg7_pkg.sv
// Shared constants, slot phase type and blanking helper for the 7-segment scan mux.
package seg7_pkg;

    localparam logic [3:0]  BLANK_CODE = 4'hF;
    localparam logic [3:0]  AN_OFF     = 4'b1111;
    localparam int unsigned NUM_DIGITS = 4;

    typedef enum logic {
        DEAD = 1'b0,
        ON   = 1'b1
    } slot_phase_t;

    // Leading-zero test: a digit other than digit 0 is blanked when it and
    // every more significant digit are zero.
    function automatic logic lz_blank(input logic [15:0] digits, input logic [1:0] idx);
        logic all_zero;
        all_zero = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (i >= 32'(idx) && digits[4*i +: 4] != 4'h0) begin
                all_zero = 1'b0;
            end
        end
        return (idx != 2'd0) && all_zero;
    endfunction

endpackage

// File: rtl/seg7_scan_mux_scan_slot_timer.sv
// Slot timer: per-slot cycle counter, DEAD/ON phase, digit index and frame pulse.
// Next-state values are exported so the top can register its outputs on the
// same edge the phase or index changes.
import seg7_pkg::*;

module scan_slot_timer #(
    parameter int unsigned SLOT_CYC    = 50_000,
    parameter int unsigned DEAD_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    output slot_phase_t phase_nx,
    output logic [1:0]  idx_nx,
    output logic        frame_nx,
    output logic        frame_tick
);

    localparam int unsigned    CW       = $clog2(SLOT_CYC);
    localparam logic [CW-1:0]  LAST     = CW'(SLOT_CYC - 1);
    localparam logic [CW-1:0]  DEAD_END = CW'(DEAD_CYCLES);

    slot_phase_t   phase_q;
    logic [1:0]    idx_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nx;

    // Slot state register; reset restarts at digit 0 dead band.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= DEAD;
            idx_q      <= 2'd0;
            cnt_q      <= '0;
            frame_tick <= 1'b0;
        end else begin
            phase_q    <= phase_nx;
            idx_q      <= idx_nx;
            cnt_q      <= cnt_nx;
            frame_tick <= frame_nx;
        end
    end

    // Counter wrap, phase transitions and digit advance.
    always_comb begin
        cnt_nx   = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        phase_nx = phase_q;
        idx_nx   = idx_q;
        frame_nx = 1'b0;
        case (phase_q)
            DEAD: begin
                if (cnt_nx == DEAD_END) begin
                    phase_nx = ON;
                end
            end
            ON: begin
                if (cnt_q == LAST) begin
                    phase_nx = DEAD;
                    idx_nx   = idx_q + 2'd1;
                    frame_nx = (idx_q == 2'd3);
                end
            end
            default: phase_nx = DEAD;
        endcase
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Four-digit common-anode scan multiplexer with double-buffered load,
// leading-zero blanking and a dead band between digits.
import seg7_pkg::*;

module seg7_scan_mux #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned SLOT_HZ     = 1_000,
    parameter int unsigned DEAD_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        lzb_en,
    output logic        pending,
    output logic        frame_tick,
    output logic [3:0]  bcd_out,
    output logic [3:0]  an,
    output logic        dp_n
);

    localparam int unsigned SLOT_CYC = CLK_HZ / SLOT_HZ;

    slot_phase_t phase_nx;
    logic [1:0]  idx_nx;
    logic        frame_nx;

    logic [15:0] shadow_d;
    logic [3:0]  shadow_dp;
    logic [15:0] active_d;
    logic [3:0]  active_dp;

    logic [3:0]  an_nx;
    logic [3:0]  bcd_nx;
    logic        dpn_nx;

    scan_slot_timer #(
        .SLOT_CYC    (SLOT_CYC),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .phase_nx   (phase_nx),
        .idx_nx     (idx_nx),
        .frame_nx   (frame_nx),
        .frame_tick (frame_tick)
    );

    // Shadow/active buffering; the active copy only changes on the edge that
    // enters the digit 0 dead band, and a load on that edge bypasses the shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_d  <= '0;
            shadow_dp <= '0;
            active_d  <= '0;
            active_dp <= '0;
            pending   <= 1'b0;
        end else if (frame_nx) begin
            pending <= 1'b0;
            if (load) begin
                active_d  <= digits_in;
                active_dp <= dp_in;
            end else if (pending) begin
                active_d  <= shadow_d;
                active_dp <= shadow_dp;
            end
        end else if (load) begin
            shadow_d  <= digits_in;
            shadow_dp <= dp_in;
            pending   <= 1'b1;
        end
    end

    // Next display values from the upcoming slot phase and digit index.
    always_comb begin
        an_nx  = AN_OFF;
        bcd_nx = BLANK_CODE;
        dpn_nx = 1'b1;
        if (phase_nx == ON) begin
            an_nx  = ~(4'b0001 << idx_nx);
            dpn_nx = ~active_dp[idx_nx];
            if (lzb_en && lz_blank(active_d, idx_nx)) begin
                bcd_nx = BLANK_CODE;
            end else begin
                bcd_nx = active_d[{idx_nx, 2'b00} +: 4];
            end
        end
    end

    // Registered pin-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an      <= AN_OFF;
            bcd_out <= BLANK_CODE;
            dp_n    <= 1'b1;
        end else begin
            an      <= an_nx;
            bcd_out <= bcd_nx;
            dp_n    <= dpn_nx;
        end
    end

endmodule
